// File: rtl/song_pkg.sv
// Shared types and constants for the play-mode song sequencer.
// State encoding is visible on the sequencer's state output, so it is fixed here.
package song_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAY      = 3'd2,
    PAUSE     = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [2:0] PLAY_MODE = 3'd3;
  localparam logic [2:0] EDIT_MODE = 3'd2;
  localparam logic [7:0] SCORE_MAX = 8'd255;
  localparam logic [5:0] MISS_MAX  = 6'd63;

  function automatic logic [7:0] sat_score(input logic [7:0] cur, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cur} + {7'd0, inc};
    return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[7:0];
  endfunction

  function automatic logic [5:0] sat_miss(input logic [5:0] cur, input logic [1:0] inc);
    logic [6:0] sum;
    sum = {1'b0, cur} + {5'd0, inc};
    return (sum > {1'b0, MISS_MAX}) ? MISS_MAX : sum[5:0];
  endfunction

endpackage

// File: rtl/beat_timer.sv
// Free-running beat divider: counts 0..BEAT_DIV-1 while run is high, holds otherwise.
// tick marks the last cycle of a beat; clear restarts the beat from zero.
module beat_timer #(
  parameter logic [23:0] BEAT_DIV = 24'd1_000_000
) (
  input  logic clk,
  input  logic nrst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  logic [23:0] r_count;

  assign tick = run && (r_count == BEAT_DIV - 24'd1);

  always_ff @(posedge clk) begin
    if (!nrst || clear) begin
      r_count <= '0;
    end else if (run) begin
      r_count <= tick ? '0 : r_count + 24'd1;
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Play-mode scheduler: snapshots two note lanes, runs a 3-beat count-in, then
// steps bit 31 down to bit 0 per beat while judging lane-button hits.
module song_sequencer
  import song_pkg::*;
#(
  parameter logic [23:0] BEAT_DIV = 24'd1_000_000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [2:0]  mode,
  input  logic        start,
  input  logic        pause,
  input  logic [1:0]  hit,
  input  logic [31:0] note1,
  input  logic [31:0] note2,
  output logic [2:0]  state,
  output logic [4:0]  position,
  output logic [1:0]  lane_now,
  output logic        beat,
  output logic [1:0]  countdown,
  output logic [7:0]  score,
  output logic [5:0]  misses,
  output logic        done
);

  state_t      r_state, w_state_next;
  logic [4:0]  r_position, w_pos_next;
  logic [1:0]  r_countdown, w_cd_next;
  logic [31:0] r_sh1, r_sh2, w_sh1_next, w_sh2_next;
  logic [1:0]  r_cred, w_cred_next;
  logic [7:0]  r_score, w_score_next;
  logic [5:0]  r_misses, w_miss_next;
  logic        r_beat, w_beat_next;
  logic [1:0]  r_lane_now, w_lane_next;
  logic        r_done;
  logic [1:0]  w_lane_bits, w_score_inc, w_miss_inc;
  logic        w_run, w_clear, w_tick;

  assign w_run       = (r_state == COUNTDOWN) || (r_state == PLAY);
  assign w_lane_bits = {r_sh2[r_position], r_sh1[r_position]};

  beat_timer #(.BEAT_DIV(BEAT_DIV)) u_beat_timer (
    .clk   (clk),
    .nrst  (nrst),
    .run   (w_run),
    .clear (w_clear),
    .tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!nrst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_pos_next   = r_position;
    w_cd_next    = r_countdown;
    w_sh1_next   = r_sh1;
    w_sh2_next   = r_sh2;
    w_cred_next  = r_cred;
    w_score_next = r_score;
    w_miss_next  = r_misses;
    w_beat_next  = 1'b0;
    w_clear      = 1'b0;
    w_score_inc  = 2'd0;
    w_miss_inc   = 2'd0;
    if (mode != PLAY_MODE) begin
      w_state_next = IDLE;
      w_pos_next   = 5'd31;
      w_cd_next    = 2'd0;
      w_sh1_next   = '0;
      w_sh2_next   = '0;
      w_cred_next  = 2'b00;
      w_score_next = '0;
      w_miss_next  = '0;
      w_clear      = 1'b1;
    end else begin
      w_beat_next = w_tick;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            w_state_next = COUNTDOWN;
            w_pos_next   = 5'd31;
            w_cd_next    = 2'd3;
            w_sh1_next   = note1;
            w_sh2_next   = note2;
            w_cred_next  = 2'b00;
            w_score_next = '0;
            w_miss_next  = '0;
            w_clear      = 1'b1;
          end
        end
        COUNTDOWN: begin
          if (w_tick) begin
            if (r_countdown == 2'd1) begin
              w_state_next = PLAY;
              w_pos_next   = 5'd31;
              w_cd_next    = 2'd0;
            end else begin
              w_cd_next = r_countdown - 2'd1;
            end
          end
        end
        PLAY: begin
          // Hits are judged first so a hit in the tick cycle still counts for the outgoing beat.
          for (int i = 0; i < 2; i++) begin
            if (hit[i]) begin
              if (w_lane_bits[i] && !r_cred[i]) begin
                w_score_inc    = w_score_inc + 2'd1;
                w_cred_next[i] = 1'b1;
              end else begin
                w_miss_inc = w_miss_inc + 2'd1;
              end
            end
          end
          if (w_tick) begin
            for (int i = 0; i < 2; i++) begin
              if (w_lane_bits[i] && !w_cred_next[i]) w_miss_inc = w_miss_inc + 2'd1;
            end
            w_cred_next = 2'b00;
            if (r_position == 5'd0) w_state_next = DONE;
            else                    w_pos_next   = r_position - 5'd1;
          end
          if (pause && w_state_next == PLAY) w_state_next = PAUSE;
          w_score_next = sat_score(r_score, w_score_inc);
          w_miss_next  = sat_miss(r_misses, w_miss_inc);
        end
        PAUSE: begin
          if (pause) w_state_next = PLAY;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign w_lane_next = (w_state_next == PLAY) ?
                       {w_sh2_next[w_pos_next], w_sh1_next[w_pos_next]} : 2'b00;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_position  <= 5'd31;
      r_countdown <= 2'd0;
      r_sh1       <= '0;
      r_sh2       <= '0;
      r_cred      <= 2'b00;
      r_score     <= '0;
      r_misses    <= '0;
      r_beat      <= 1'b0;
      r_lane_now  <= 2'b00;
      r_done      <= 1'b0;
    end else begin
      r_position  <= w_pos_next;
      r_countdown <= w_cd_next;
      r_sh1       <= w_sh1_next;
      r_sh2       <= w_sh2_next;
      r_cred      <= w_cred_next;
      r_score     <= w_score_next;
      r_misses    <= w_miss_next;
      r_beat      <= w_beat_next;
      r_lane_now  <= w_lane_next;
      r_done      <= (w_state_next == DONE);
    end
  end

  assign state     = r_state;
  assign position  = r_position;
  assign lane_now  = r_lane_now;
  assign beat      = r_beat;
  assign countdown = r_countdown;
  assign score     = r_score;
  assign misses    = r_misses;
  assign done      = r_done;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed song scenarios plus randomized play,
// all outputs compared every cycle against a song-level reference model.
module tb_song_sequencer;

  localparam int B = 4;
  localparam int S_IDLE = 0, S_CD = 1, S_PLAY = 2, S_PAUSE = 3, S_DONE = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic [2:0]  mode;
  logic        start, pause;
  logic [1:0]  hit;
  logic [31:0] note1, note2;
  logic [2:0]  state;
  logic [4:0]  position;
  logic [1:0]  lane_now, countdown;
  logic        beat, done;
  logic [7:0]  score;
  logic [5:0]  misses;

  always #5 clk = ~clk;

  song_sequencer #(.BEAT_DIV(24'(B))) dut (
    .clk(clk), .nrst(nrst), .mode(mode), .start(start), .pause(pause), .hit(hit),
    .note1(note1), .note2(note2), .state(state), .position(position),
    .lane_now(lane_now), .beat(beat), .countdown(countdown), .score(score),
    .misses(misses), .done(done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: song phase, beat index into the snapshot, raw hit/miss totals.
  int          m_st, m_cd, m_idx, m_timer, m_hits, m_miss, m_beat;
  logic [31:0] m_snap1, m_snap2;
  bit          m_cred [2];

  function automatic logic lane_bit(input int lane, input int idx);
    logic [31:0] w;
    w = (lane == 0) ? m_snap1 : m_snap2;
    return w[5'(31 - idx)];
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_cd = 0; m_idx = 0; m_timer = 0; m_hits = 0; m_miss = 0;
    m_beat = 0; m_snap1 = '0; m_snap2 = '0; m_cred[0] = 0; m_cred[1] = 0;
  endtask

  task automatic model_step(input logic n, input logic [2:0] md, input logic st,
                            input logic pa, input logic [1:0] h);
    bit running, tk;
    if (!n || md != 3'd3) begin
      model_reset();
      return;
    end
    running = (m_st == S_CD) || (m_st == S_PLAY);
    tk      = running && (m_timer == B - 1);
    m_beat  = tk ? 1 : 0;
    case (m_st)
      S_IDLE, S_DONE: if (st) begin
        m_snap1 = note1; m_snap2 = note2; m_hits = 0; m_miss = 0;
        m_cd = 3; m_timer = 0; m_idx = 0; m_st = S_CD;
        m_cred[0] = 0; m_cred[1] = 0;
      end
      S_CD: if (tk) begin
        if (m_cd == 1) begin m_st = S_PLAY; m_idx = 0; end
        else m_cd--;
      end
      S_PLAY: begin
        for (int i = 0; i < 2; i++) begin
          if (h[i]) begin
            if (lane_bit(i, m_idx) && !m_cred[i]) begin m_hits++; m_cred[i] = 1; end
            else m_miss++;
          end
        end
        if (tk) begin
          for (int i = 0; i < 2; i++) if (lane_bit(i, m_idx) && !m_cred[i]) m_miss++;
          m_cred[0] = 0; m_cred[1] = 0;
          if (m_idx == 31) m_st = S_DONE;
          else m_idx++;
        end
        if (pa && m_st == S_PLAY) m_st = S_PAUSE;
      end
      S_PAUSE: if (pa) m_st = S_PLAY;
      default: ;
    endcase
    if (running) m_timer = tk ? 0 : m_timer + 1;
  endtask

  task automatic compare_outputs();
    int e_pos, e_lane;
    e_pos  = (m_st == S_DONE) ? 0 : ((m_st == S_PLAY || m_st == S_PAUSE) ? 31 - m_idx : 31);
    e_lane = (m_st == S_PLAY) ? {30'd0, lane_bit(1, m_idx), lane_bit(0, m_idx)} : 0;
    check_eq("state",     32'(state),     32'(m_st));
    check_eq("position",  32'(position),  32'(e_pos));
    check_eq("lane_now",  32'(lane_now),  32'(e_lane));
    check_eq("beat",      32'(beat),      32'(m_beat));
    check_eq("countdown", 32'(countdown), (m_st == S_CD) ? 32'(m_cd) : 32'd0);
    check_eq("score",     32'(score),     (m_hits > 255) ? 32'd255 : 32'(m_hits));
    check_eq("misses",    32'(misses),    (m_miss > 63) ? 32'd63 : 32'(m_miss));
    check_eq("done",      32'(done),      (m_st == S_DONE) ? 32'd1 : 32'd0);
  endtask

  task automatic drive(input logic n, input logic [2:0] md, input logic st,
                       input logic pa, input logic [1:0] h);
    nrst = n; mode = md; start = st; pause = pa; hit = h;
    @(posedge clk);
    model_step(n, md, st, pa, h);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b1, 3'd3, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic wait_play();
    int cnt;
    cnt = 0;
    while (m_st != S_PLAY && cnt < 40) begin idle(1); cnt++; end
    check_eq("reach_play", 32'(state), 32'(S_PLAY));
  endtask

  task automatic wait_done(input logic [1:0] h_lane);
    int cnt;
    cnt = 0;
    while (m_st != S_DONE && cnt < 400) begin
      drive(1'b1, 3'd3, 1'b0, 1'b0, (m_st == S_PLAY && m_timer == 1) ? h_lane : 2'b00);
      cnt++;
    end
    check_eq("reach_done", 32'(state), 32'(S_DONE));
  endtask

  initial begin
    int cnt, s0, m0;
    logic [1:0] h;
    logic [2:0] md;
    nrst = 1'b0; mode = 3'd3; start = 1'b0; pause = 1'b0; hit = 2'b00;
    note1 = '0; note2 = '0;
    model_reset();
    @(negedge clk);

    // Reset state
    drive(1'b0, 3'd3, 1'b0, 1'b0, 2'b00);
    drive(1'b0, 3'd3, 1'b1, 1'b0, 2'b11);
    idle(3);

    // Sparse pattern, no hits: count-in plus 32 beats
    note1 = 32'h8000_0001; note2 = 32'h0;
    drive(1'b1, 3'd3, 1'b1, 1'b0, 2'b00);
    cnt = 0;
    while (state != 3'(S_DONE) && cnt < 400) begin idle(1); cnt++; end
    check_eq("a_done_latency", 32'(cnt), 32'd140);
    check_eq("a_misses", 32'(misses), 32'd2);
    check_eq("a_score", 32'(score), 32'd0);

    // All-ones lane 1, one hit per beat (restart from DONE)
    note1 = 32'hFFFF_FFFF; note2 = 32'h0;
    drive(1'b1, 3'd3, 1'b1, 1'b0, 2'b00);
    wait_done(2'b01);
    check_eq("b_score", 32'(score), 32'd32);
    check_eq("b_misses", 32'(misses), 32'd0);
    check_eq("b_done", 32'(done), 32'd1);

    // Wrong lane and duplicate in one beat
    drive(1'b1, 3'd3, 1'b1, 1'b0, 2'b00);
    wait_play();
    idle(1);
    s0 = int'(score); m0 = int'(misses);
    drive(1'b1, 3'd3, 1'b0, 1'b0, 2'b11);
    drive(1'b1, 3'd3, 1'b0, 1'b0, 2'b01);
    check_eq("c_score_delta", 32'(score), 32'(s0 + 1));
    check_eq("c_miss_delta", 32'(misses), 32'(m0 + 2));
    idle(3);

    // Leave play mode mid-song, then restart with fresh notes
    drive(1'b1, 3'd2, 1'b0, 1'b0, 2'b00);
    check_eq("f_mode_state", 32'(state), 32'(S_IDLE));
    check_eq("f_mode_pos", 32'(position), 32'd31);
    check_eq("f_mode_score", 32'(score), 32'd0);
    note1 = 32'hA5C3_0F96; note2 = 32'h5A3C_F069;
    drive(1'b1, 3'd3, 1'b1, 1'b0, 2'b00);
    note1 = 32'h0; note2 = 32'h0;
    wait_play();
    check_eq("f_lane_first", 32'(lane_now), 32'd1);
    idle(10);
    drive(1'b0, 3'd3, 1'b0, 1'b0, 2'b00);
    check_eq("f_rst_state", 32'(state), 32'(S_IDLE));
    check_eq("f_rst_pos", 32'(position), 32'd31);
    check_eq("f_rst_score", 32'(score), 32'd0);

    // Pause at position 20 for 50 cycles
    note1 = $urandom; note2 = $urandom;
    drive(1'b1, 3'd3, 1'b1, 1'b0, 2'b00);
    cnt = 0;
    while (!(m_st == S_PLAY && m_idx == 11 && m_timer == 1) && cnt < 300) begin idle(1); cnt++; end
    drive(1'b1, 3'd3, 1'b0, 1'b1, 2'b00);
    check_eq("d_paused", 32'(state), 32'(S_PAUSE));
    for (int k = 0; k < 50; k++) begin
      drive(1'b1, 3'd3, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
      check_eq("d_pos_hold", 32'(position), 32'd20);
    end
    drive(1'b1, 3'd3, 1'b0, 1'b1, 2'b00);
    cnt = 0;
    while (!beat && cnt < 20) begin idle(1); cnt++; end
    check_eq("d_resume_tick", 32'(cnt), 32'(B - 2));
    check_eq("d_pos_after", 32'(position), 32'd19);
    wait_done(2'b00);

    // Miss counter saturation
    note1 = 32'h0; note2 = 32'h0;
    drive(1'b1, 3'd3, 1'b1, 1'b0, 2'b00);
    wait_play();
    for (int k = 0; k < 40; k++) drive(1'b1, 3'd3, 1'b0, 1'b0, 2'b11);
    check_eq("e_miss_sat", 32'(misses), 32'd63);
    idle(5);
    drive(1'b1, 3'd0, 1'b0, 1'b0, 2'b00);

    // Randomized play
    for (int blk = 0; blk < 4; blk++) begin
      note1 = $urandom; note2 = $urandom;
      drive(1'b1, 3'd3, 1'b1, 1'b0, 2'b00);
      for (int k = 0; k < 600; k++) begin
        h  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        md = ($urandom_range(0, 299) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
        if ($urandom_range(0, 19) == 0) note1 = $urandom;
        if ($urandom_range(0, 19) == 0) note2 = $urandom;
        drive(($urandom_range(0, 299) != 0), md, ($urandom_range(0, 29) == 0),
              ($urandom_range(0, 39) == 0), h);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Play-mode scheduler for the two 32-bit note lanes built by the song editor. On a start pulse it snapshots both lane patterns and runs a 3-beat count-in. It then steps a position pointer from bit 31 down to bit 0 at a fixed tempo, presenting the active notes each beat. It judges the player's lane-button pulses against the pattern and accumulates score and miss counts for the display logic.

## Interface
- BEAT_DIV, 24'd1_000_000, clock cycles per beat (legal range ≥ 2)
- clk  input  1  system clock
- nrst  input  1  reset: synchronous and active-low
- mode  input  3  game mode; the sequencer is active only when mode == PLAY_MODE
- start  input  1  single-cycle pulse, already edge-detected upstream
- pause  input  1  single-cycle pulse, already edge-detected upstream
- hit  input  2  single-cycle lane-button pulses; bit0 = lane1, bit1 = lane2
- note1, note2  input  32  lane patterns from the editor; MSB is played first
- state  output  3  current FSM state (song_pkg encoding)
- position  output  5  current pattern index
- lane_now  output  2  {note2[position], note1[position]} of the snapshot during PLAY, else 0
- beat  output  1  one-cycle pulse at each beat boundary in COUNTDOWN and PLAY
- countdown  output  2  count-in value 3,2,1 during COUNTDOWN, else 0
- score  output  8  correct hits, saturating at 255
- misses  output  6  misses, saturating at 63
- done  output  1  high while in DONE

## Operation
- States:
  - IDLE: waiting for start.
  - COUNTDOWN: 3-beat count-in.
  - PLAY: stepping through the pattern.
  - PAUSE: timer frozen.
  - DONE: song finished.
- IDLE + start: snapshot note1/note2 into shadow registers; clear score, misses and beat timer; countdown = 3; go to COUNTDOWN.
- Editor changes after the snapshot have no effect on the song in progress.
- COUNTDOWN: countdown decrements on each beat tick. The tick taken at countdown == 1 enters PLAY with position = 31 and timer = 0.
- PLAY, per beat, each lane i is judged independently:
  - hit[i] with snapshot bit = 1 and lane not yet credited this beat: score +1, lane marked credited.
  - hit[i] with snapshot bit = 0: misses +1.
  - hit[i] on a lane already credited this beat: misses +1.
  - At the beat tick, each lane with snapshot bit = 1 and not credited: misses +1. Credited flags then clear.
- Both lanes can change the counters in the same cycle. Increments sum, then saturate.
- PLAY beat tick at position 0: go to DONE and hold position at 0. Otherwise position decrements.
- PLAY + pause: go to PAUSE. PAUSE + pause: return to PLAY, timer resumes from its held value.
- pause is ignored in every other state. hit is ignored outside PLAY.
- start is ignored in COUNTDOWN, PLAY and PAUSE. DONE + start behaves exactly as IDLE + start (restart with a new snapshot).
- mode != PLAY_MODE in any state: next cycle, all registers return to their reset values and the state is IDLE.

## Timing
- Reset values, taken at the first clk edge with nrst = 0: state IDLE, position 31, lane_now 0, beat 0, countdown 0, score 0, misses 0, done 0, shadows 0, timer 0.
- Reset mid-song aborts at that same edge; no partial counter update is applied.
- Beat timer counts 0..BEAT_DIV-1. The tick is the cycle where timer == BEAT_DIV-1; the timer wraps to 0 on that cycle.
- beat is registered and asserts the cycle after the tick.
- The first PLAY beat tick occurs BEAT_DIV cycles after entering PLAY.
- A full song is 32·BEAT_DIV cycles from PLAY entry to DONE, excluding pause time.
- All outputs are registered. A hit pulse updates score/misses one cycle after it is sampled.
- A hit sampled in the tick cycle is judged against the outgoing beat, before the credited flags clear.
- start, pause and mode change in the same cycle: the mode check wins, then pause, then start.

## Structure
- song_pkg holds:
  - state enum: IDLE=0, COUNTDOWN=1, PLAY=2, PAUSE=3, DONE=4.
  - PLAY_MODE = 3'd3 and EDIT_MODE = 3'd2.
  - SCORE_MAX = 255, MISS_MAX = 63.
- Sub-module beat_timer: parameter BEAT_DIV; inputs clk, nrst, run, clear; output tick. run is high only in COUNTDOWN and PLAY.
- FSM, judging logic and counters sit in song_sequencer. Expected size is about 200–300 lines.

## Test plan
- BEAT_DIV=4, note1=32'h8000_0001, note2=0, no hits: state → DONE after 12+128 cycles; misses = 2, score = 0.
- note1=32'hFFFF_FFFF, hit[0] pulsed once per beat mid-beat: score = 32, misses = 0, done = 1.
- Same beat: hit = 2'b11 on pattern bits {1,0}, then hit[0] again: score +1, misses +2 (wrong lane, then duplicate).
- Pause at position 20 for 50 cycles, then resume: position stays 20 throughout, and the next tick comes exactly the remaining timer count after resume.
- score at 255 with further correct hits: score holds 255. misses at 63: misses holds 63.
- Mid-PLAY, either nrst=0 for one cycle or mode changed to 3'd2: next edge gives state IDLE, position 31, score 0; a following start recaptures the current note1/note2.
